// File: rtl/msg_pkg.sv
// Shared packet geometry for the message assembler and its disassembler,
// plus a width helper for the small counters in this block.
package msg_pkg;
   localparam int MSG_WORD_SIZE        = 8;
   localparam int MSG_WORDS_PER_PACKET = 4;
   localparam int MSG_TIMEOUT_CYCLES   = 1000;

   // Bits needed to count 0..n-1, never narrower than one bit.
   function automatic int msg_cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/msg_timeout.sv
// Inter-word idle watchdog: counts idle cycles while enabled and flags when
// the count has reached TIMEOUT_CYCLES (never flags when TIMEOUT_CYCLES is 0).
module msg_timeout
   import msg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = MSG_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int            IW       = msg_cnt_w(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic          at_max;

   assign at_max  = (idle_cnt_q == IDLE_MAX);
   assign expired = (TIMEOUT_CYCLES != 0) && enable && at_max;

   // Saturate at the threshold so a held-off expiry cannot wrap around.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (clear || !enable) begin
         idle_cnt_d = '0;
      end else if (!at_max) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
endmodule

// File: rtl/msg_asm.sv
// Assembles WORDS_PER_PACKET received UART words into one message and issues
// a single FIFO write per completed packet; flags dropped words and timeouts.
module msg_asm
   import msg_pkg::*;
#(
   parameter int WORD_SIZE        = MSG_WORD_SIZE,
   parameter int WORDS_PER_PACKET = MSG_WORDS_PER_PACKET,
   parameter int TIMEOUT_CYCLES   = MSG_TIMEOUT_CYCLES
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [WORD_SIZE-1:0]                  data_in,
   input  logic                                  data_in_valid,
   input  logic                                  fifo_full,
   output logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out,
   output logic                                  data_out_req,
   output logic                                  overflow,
   output logic                                  timeout
);
   localparam int            MW        = WORD_SIZE * WORDS_PER_PACKET;
   localparam int            CW        = msg_cnt_w(WORDS_PER_PACKET + 1);
   localparam logic [CW-1:0] LAST_SLOT = CW'(WORDS_PER_PACKET - 1);

   typedef enum logic [1:0] {
      SM_IDLE    = 2'd0,
      SM_COLLECT = 2'd1,
      SM_WRITE   = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] word_cnt_q, word_cnt_d;
   logic [MW-1:0] asm_buf_q, asm_buf_d;
   logic [MW-1:0] data_out_q, data_out_d;
   logic          overflow_q, overflow_d;
   logic          timeout_q, timeout_d;
   logic          idle_expired, idle_clear, idle_enable;

   msg_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (idle_clear),
      .enable (idle_enable),
      .expired(idle_expired)
   );

   assign idle_enable  = (state_q == SM_COLLECT);
   assign idle_clear   = data_in_valid && (state_q != SM_WRITE);
   // Gated by reset so a pending write is never strobed while reset is held.
   assign data_out_req = (state_q == SM_WRITE) && !fifo_full && !reset;
   assign data_out     = data_out_q;
   assign overflow     = overflow_q;
   assign timeout      = timeout_q;

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      asm_buf_d  = asm_buf_q;
      data_out_d = data_out_q;
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
      case (state_q)
         SM_IDLE: begin
            if (data_in_valid) begin
               asm_buf_d[WORD_SIZE-1:0] = data_in;
               word_cnt_d = CW'(1);
               if (WORDS_PER_PACKET == 1) begin
                  state_d    = SM_WRITE;
                  data_out_d = asm_buf_d;
               end else begin
                  state_d = SM_COLLECT;
               end
            end
         end
         SM_COLLECT: begin
            if (data_in_valid) begin
               asm_buf_d[int'(word_cnt_q)*WORD_SIZE +: WORD_SIZE] = data_in;
               word_cnt_d = word_cnt_q + 1'b1;
               if (word_cnt_q == LAST_SLOT) begin
                  state_d    = SM_WRITE;
                  data_out_d = asm_buf_d;
               end
            end else if (idle_expired) begin
               state_d    = SM_IDLE;
               word_cnt_d = '0;
               timeout_d  = 1'b1;
            end
         end
         SM_WRITE: begin
            overflow_d = data_in_valid;
            if (!fifo_full) begin
               state_d    = SM_IDLE;
               word_cnt_d = '0;
            end
         end
         default: begin
            state_d    = SM_IDLE;
            word_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SM_IDLE;
         word_cnt_q <= '0;
         asm_buf_q  <= '0;
         data_out_q <= '0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         asm_buf_q  <= asm_buf_d;
         data_out_q <= data_out_d;
         overflow_q <= overflow_d;
         timeout_q  <= timeout_d;
      end
   end
endmodule

// File: tb/tb_msg_asm.sv
// Directed bench for msg_asm: 4 x 8-bit packets, 10-cycle inter-word timeout,
// hand-computed expected messages and pulse counts.
module tb_msg_asm;
   localparam int WS  = 8;
   localparam int WPP = 4;
   localparam int TO  = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic [WS-1:0]     data_in;
   logic              data_in_valid;
   logic              fifo_full;
   logic [WS*WPP-1:0] data_out;
   logic              data_out_req;
   logic              overflow;
   logic              timeout;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          req_cnt = 0;
   int          ovf_cnt = 0;
   int          to_cnt  = 0;
   logic [31:0] wr_log[$];
   int          r0, o0, t0, i0;
   logic [31:0] w0, w1;

   msg_asm #(
      .WORD_SIZE       (WS),
      .WORDS_PER_PACKET(WPP),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .data_in_valid(data_in_valid),
      .fifo_full    (fifo_full),
      .data_out     (data_out),
      .data_out_req (data_out_req),
      .overflow     (overflow),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (data_out_req) begin
         req_cnt++;
         wr_log.push_back(data_out);
      end
      if (overflow) ovf_cnt++;
      if (timeout) to_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] w);
      data_in       = w;
      data_in_valid = 1'b1;
      tick();
      data_in_valid = 1'b0;
   endtask

   task automatic send_pkt(input logic [31:0] p);
      for (int k = 0; k < WPP; k++) send(p[k*8 +: 8]);
   endtask

   initial begin
      reset         = 1'b1;
      data_in       = '0;
      data_in_valid = 1'b0;
      fifo_full     = 1'b0;
      idle(3);
      @(negedge clk);
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_req", 32'(data_out_req), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      // basic packet, write one cycle after the last word
      r0 = req_cnt;
      send_pkt(32'h44332211);
      @(negedge clk);
      chk("s1_req", 32'(data_out_req), 32'd1);
      chk("s1_data", data_out, 32'h44332211);
      tick();
      @(negedge clk);
      chk("s1_req_low", 32'(data_out_req), 32'd0);
      tick();
      chk("s1_req_once", req_cnt - r0, 32'd1);

      // FIFO full for 20 cycles
      fifo_full = 1'b1;
      r0 = req_cnt;
      send_pkt(32'h64636261);
      @(negedge clk);
      chk("s2_data_early", data_out, 32'h64636261);
      chk("s2_req_held", 32'(data_out_req), 32'd0);
      idle(20);
      chk("s2_no_req_full", req_cnt - r0, 32'd0);
      fifo_full = 1'b0;
      @(negedge clk);
      chk("s2_req", 32'(data_out_req), 32'd1);
      tick();
      @(negedge clk);
      chk("s2_req_low", 32'(data_out_req), 32'd0);
      tick();
      chk("s2_req_once", req_cnt - r0, 32'd1);

      // word arriving while held in SM_WRITE
      fifo_full = 1'b1;
      send_pkt(32'h74737271);
      o0 = ovf_cnt;
      r0 = req_cnt;
      send(8'h55);
      @(negedge clk);
      chk("s3_overflow", 32'(overflow), 32'd1);
      tick();
      @(negedge clk);
      chk("s3_overflow_low", 32'(overflow), 32'd0);
      chk("s3_data_kept", data_out, 32'h74737271);
      tick();
      fifo_full = 1'b0;
      idle(2);
      chk("s3_ovf_once", ovf_cnt - o0, 32'd1);
      chk("s3_req_once", req_cnt - r0, 32'd1);
      send_pkt(32'hA3A2A1A0);
      @(negedge clk);
      chk("s3_next_data", data_out, 32'hA3A2A1A0);
      chk("s3_next_req", 32'(data_out_req), 32'd1);
      tick();

      // partial packet then idle past the timeout
      t0 = to_cnt;
      r0 = req_cnt;
      send(8'h01);
      send(8'h02);
      idle(9);
      chk("s4_no_early_to", to_cnt - t0, 32'd0);
      idle(6);
      chk("s4_to_once", to_cnt - t0, 32'd1);
      chk("s4_no_write", req_cnt - r0, 32'd0);
      chk("s4_data_kept", data_out, 32'hA3A2A1A0);
      send_pkt(32'h0D0C0B0A);
      @(negedge clk);
      chk("s4_next_data", data_out, 32'h0D0C0B0A);
      tick();

      // word arriving on the threshold cycle is accepted
      t0 = to_cnt;
      send(8'hC0);
      idle(TO);
      send(8'hC1);
      send(8'hC2);
      send(8'hC3);
      @(negedge clk);
      chk("s4b_data", data_out, 32'hC3C2C1C0);
      chk("s4b_req", 32'(data_out_req), 32'd1);
      idle(3);
      chk("s4b_no_to", to_cnt - t0, 32'd0);

      // reset after three words
      r0 = req_cnt;
      t0 = to_cnt;
      send(8'h81);
      send(8'h82);
      send(8'h83);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      idle(15);
      chk("s5_no_write", req_cnt - r0, 32'd0);
      chk("s5_no_to", to_cnt - t0, 32'd0);
      chk("s5_data_clr", data_out, 32'h0);
      send_pkt(32'h94939291);
      @(negedge clk);
      chk("s5_next_data", data_out, 32'h94939291);
      tick();

      // reset while a write is pending
      fifo_full = 1'b1;
      send_pkt(32'hE3E2E1E0);
      r0 = req_cnt;
      reset     = 1'b1;
      fifo_full = 1'b0;
      @(negedge clk);
      chk("s5b_req_in_rst", 32'(data_out_req), 32'd0);
      tick();
      reset = 1'b0;
      idle(3);
      chk("s5b_write_cancel", req_cnt - r0, 32'd0);

      // back-to-back words, one per cycle
      r0 = req_cnt;
      o0 = ovf_cnt;
      i0 = wr_log.size();
      for (int k = 0; k < 9; k++) begin
         data_in       = 8'(176 + k);
         data_in_valid = 1'b1;
         tick();
      end
      data_in_valid = 1'b0;
      idle(3);
      chk("s6_req_cnt", req_cnt - r0, 32'd2);
      chk("s6_ovf_cnt", ovf_cnt - o0, 32'd1);
      w0 = (wr_log.size() > i0) ? wr_log[i0] : 32'h0;
      w1 = (wr_log.size() > i0 + 1) ? wr_log[i0+1] : 32'h0;
      chk("s6_pkt0", w0, 32'hB3B2B1B0);
      chk("s6_pkt1", w1, 32'hB8B7B6B5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/msg_asm.md
MSG_ASM -- requirements
Module: msg_asm

Interface
REQ-001 Parameter WORD_SIZE, default 8, bits per received UART word.
REQ-002 Parameter WORDS_PER_PACKET, default 4, words per assembled message.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000, maximum idle clk cycles between words of one packet; 0 disables the timeout.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port data_in, input, WORD_SIZE, received word from the UART receiver.
REQ-008 Port data_in_valid, input, 1, single-cycle strobe; data_in is valid in this cycle.
REQ-009 Port fifo_full, input, 1, high when the downstream FIFO cannot accept a write.
REQ-010 Port data_out, output, WORD_SIZE*WORDS_PER_PACKET, assembled message, registered.
REQ-011 Port data_out_req, output, 1, FIFO write strobe for data_out.
REQ-012 Port overflow, output, 1, single-cycle pulse when an incoming word is dropped.
REQ-013 Port timeout, output, 1, single-cycle pulse when a partial packet is discarded.

Function
REQ-014 Word k of a packet, counting from 0 in arrival order, SHALL occupy data_out bits [(k+1)*WORD_SIZE-1 : k*WORD_SIZE].
REQ-015 The FSM SHALL have states SM_IDLE, SM_COLLECT and SM_WRITE.
REQ-016 In SM_IDLE, data_in_valid SHALL store the word in slot 0, set the word counter to 1, and go to SM_COLLECT.
REQ-017 In SM_IDLE when WORDS_PER_PACKET==1, data_in_valid SHALL instead go directly to SM_WRITE.
REQ-018 In SM_COLLECT, data_in_valid SHALL store the word at the counter slot and increment the counter.
REQ-019 When the stored word is slot WORDS_PER_PACKET-1, the FSM SHALL go to SM_WRITE.
REQ-020 Entering SM_WRITE SHALL copy the full assembly buffer, including the final word, into data_out in that same clock edge.
REQ-021 data_out SHALL stay stable until the next completed packet is copied.
REQ-022 data_out_req SHALL be asserted combinationally as (state==SM_WRITE && !fifo_full).
REQ-023 The FSM SHALL leave SM_WRITE for SM_IDLE in the cycle data_out_req is high.
REQ-024 Exactly one data_out_req SHALL be issued per completed packet, however long fifo_full stays high.
REQ-025 Minimum latency SHALL be one cycle: last data_in_valid in cycle N gives data_out_req in cycle N+1 when fifo_full is low.
REQ-026 A data_in_valid in SM_WRITE SHALL drop the word and pulse overflow in the next cycle, including the cycle data_out_req is asserted.
REQ-027 An idle counter SHALL clear on every accepted word and increment each SM_COLLECT cycle without data_in_valid.
REQ-028 When the idle counter reaches TIMEOUT_CYCLES, and TIMEOUT_CYCLES>0, the FSM SHALL discard the partial packet, go to SM_IDLE, and pulse timeout for one cycle.
REQ-029 A timeout SHALL leave data_out unchanged.
REQ-030 data_in_valid in the same cycle the timeout threshold is reached SHALL be accepted, and no timeout SHALL occur.
REQ-031 Counter width SHALL be $clog2(WORDS_PER_PACKET+1); the idle counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1.

Reset
REQ-032 Reset SHALL set state to SM_IDLE and clear both counters, data_out, overflow and timeout.
REQ-033 data_out_req SHALL be 0 in any cycle reset is high.
REQ-034 Reset mid-packet SHALL discard the partial packet with no write and no timeout pulse.
REQ-035 Reset in SM_WRITE SHALL cancel the pending write.

Structure
REQ-036 State encodings SHALL be local parameters of msg_asm, 2 bits wide.
REQ-037 A shared msg_pkg SHALL hold the WORD_SIZE and WORDS_PER_PACKET defaults, so msg_asm and the disassembler agree on packet geometry.
REQ-038 The inter-word timeout SHALL be one sub-module, msg_timeout (clk, reset, clear, enable, expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-039 Scenario: defaults, words 0x11, 0x22, 0x33, 0x44 with fifo_full=0 -> data_out=0x44332211, one data_out_req one cycle after 0x44.
REQ-040 Scenario: same packet with fifo_full=1 for 20 cycles -> data_out_req only on the first cycle fifo_full=0, exactly once.
REQ-041 Scenario: word 0x55 arrives while held in SM_WRITE -> overflow pulse; the next packet 0xA0..0xA3 assembles to 0xA3A2A1A0.
REQ-042 Scenario: TIMEOUT_CYCLES=10, words 0x01, 0x02 then 10 idle cycles -> timeout pulse, no write; then 0x0A..0x0D -> data_out=0x0D0C0B0A.
REQ-043 Scenario: reset asserted after 3 of 4 words -> no data_out_req, data_out=0; the next full packet writes correctly.
REQ-044 Scenario: back-to-back packets with one word per cycle and fifo_full=0 -> the word after the last is dropped with overflow; otherwise every packet is written in order.
